alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 60 ++++++
 rtl/alu_arbiter.sv | 89 ++++++++
 tb/tb_alu_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and state encodings plus status flag positions shared by the ALU arbiter
package alu_pkg;

    typedef enum logic [1:0] {
        OP_SUB  = 2'b00,
        OP_LT   = 2'b01,
        OP_CLR  = 2'b10,
        OP_CONV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int ST_ERR  = 0;
    localparam int ST_SIGN = 1;
    localparam int ST_EVEN = 2;
    localparam int ST_ONES = 3;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational sign-magnitude ALU producing a result and its status flags
module alu_core
    import alu_pkg::*;
#(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic [n-1:0] op,
    input  logic [m-1:0] A,
    input  logic [m-1:0] B,
    output logic [m-1:0] result,
    output logic [3:0]   status
);

    logic [m-2:0]      mag_a;
    logic [m-2:0]      mag_b;
    logic signed [m:0] va;
    logic signed [m:0] vb;
    logic signed [m:0] diff;
    logic signed [m:0] adiff;
    logic [m-1:0]      neg_a;
    logic [m-1:0]      res;
    logic              err;

    always_comb begin
        mag_a  = A[m-2:0];
        mag_b  = B[m-2:0];
        // one extra bit so both the difference and its magnitude stay representable
        va     = A[m-1] ? -$signed({2'b00, mag_a}) : $signed({2'b00, mag_a});
        vb     = B[m-1] ? -$signed({2'b00, mag_b}) : $signed({2'b00, mag_b});
        diff   = va - vb;
        adiff  = diff[m] ? -diff : diff;
        neg_a  = ~{1'b0, mag_a} + m'(1);
        res    = '0;
        err    = 1'b0;
        case (op_t'(op[1:0]))
            OP_SUB: begin
                err = |adiff[m:m-1];
                res = {diff[m], adiff[m-2:0]};
            end
            OP_LT: res = m'(va < vb);
            OP_CLR: begin
                err = B[m-1] || int'(B) >= m;
                res = A & ~(m'(1) << B);
            end
            OP_CONV: begin
                err = mag_a == '0;
                res = A[m-1] ? neg_a : A;
            end
            default: res = '0;
        endcase
        result           = err ? '0 : res;
        status           = '0;
        status[ST_ERR]   = err;
        status[ST_SIGN]  = !err && result[m-1];
        status[ST_EVEN]  = !err && !(^result);
        status[ST_ONES]  = !err && (&result);
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter feeding a shared ALU through an IDLE/EXEC/RESP handshake
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [1:0]   i_req,
    input  logic [n-1:0] i_op0,
    input  logic [n-1:0] i_op1,
    input  logic [m-1:0] i_argA0,
    input  logic [m-1:0] i_argB0,
    input  logic [m-1:0] i_argA1,
    input  logic [m-1:0] i_argB1,
    input  logic         i_ack,
    output logic [1:0]   o_gnt,
    output logic         o_valid,
    output logic         o_id,
    output logic [m-1:0] o_result,
    output logic [3:0]   o_status,
    output logic         o_busy
);

    state_t       state;
    logic         last;
    logic         win;
    logic         pick;
    logic [n-1:0] op_r;
    logic [m-1:0] a_r;
    logic [m-1:0] b_r;
    logic [m-1:0] res;
    logic [3:0]   st;

    // under contention the requester not served last wins
    assign pick   = (&i_req) ? ~last : i_req[1];
    assign o_busy = state != IDLE;

    alu_core #(.m(m), .n(n)) u_core (
        .op     (op_r),
        .A      (a_r),
        .B      (b_r),
        .result (res),
        .status (st)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            win      <= 1'b0;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            o_gnt    <= '0;
            o_valid  <= 1'b0;
            o_id     <= 1'b0;
            o_result <= '0;
            o_status <= '0;
        end else begin
            case (state)
                IDLE: if (|i_req) begin
                    win   <= pick;
                    op_r  <= pick ? i_op1 : i_op0;
                    a_r   <= pick ? i_argA1 : i_argA0;
                    b_r   <= pick ? i_argB1 : i_argB0;
                    o_gnt <= pick ? 2'b10 : 2'b01;
                    state <= EXEC;
                end
                EXEC: begin
                    o_gnt    <= '0;
                    o_result <= res;
                    o_status <= st;
                    o_valid  <= 1'b1;
                    o_id     <= win;
                    state    <= RESP;
                end
                RESP: if (i_ack) begin
                    o_valid <= 1'b0;
                    last    <= o_id;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a reference model
module tb_alu_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_ack;
    logic [1:0] i_req;
    logic [1:0] i_op0, i_op1;
    logic [3:0] i_argA0, i_argB0, i_argA1, i_argB1;
    logic [1:0] o_gnt;
    logic       o_valid, o_id, o_busy;
    logic [3:0] o_result, o_status;

    int errors = 0;
    int checks = 0;
    bit last_gnt;

    always #5 i_clk = ~i_clk;

    alu_arbiter #(.m(4), .n(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_op0(i_op0), .i_op1(i_op1),
        .i_argA0(i_argA0), .i_argB0(i_argB0), .i_argA1(i_argA1), .i_argB1(i_argB1),
        .i_ack(i_ack), .o_gnt(o_gnt), .o_valid(o_valid), .o_id(o_id),
        .o_result(o_result), .o_status(o_status), .o_busy(o_busy)
    );

    function automatic int sm(input logic [3:0] x);
        return x[3] ? -int'(x[2:0]) : int'(x[2:0]);
    endfunction

    function automatic void model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] r, output logic [3:0] s);
        int d;
        bit e;
        e = 0;
        r = 0;
        case (op)
            2'd0: begin
                d = sm(a) - sm(b);
                if (d > 7 || d < -7) e = 1;
                else r = d < 0 ? 4'(8 - d) : 4'(d);
            end
            2'd1: r = (sm(a) < sm(b)) ? 4'd1 : 4'd0;
            2'd2: if (b >= 4) e = 1; else begin r = a; r[b[1:0]] = 1'b0; end
            default: if (a[2:0] == 0) e = 1; else r = a[3] ? 4'(16 - int'(a[2:0])) : a;
        endcase
        if (e) begin r = 0; s = 4'b0001; end
        else s = {r == 4'hF, ($countones(r) % 2) == 0, r[3], 1'b0};
    endfunction

    task automatic txn(input logic [1:0] req, input logic [1:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic [1:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                       output logic [1:0] g, output logic v_early, output logic v, output logic id,
                       output logic [3:0] r, output logic [3:0] s);
        i_req = req; i_op0 = op0; i_argA0 = a0; i_argB0 = b0; i_op1 = op1; i_argA1 = a1; i_argB1 = b1;
        @(posedge i_clk); #1;
        g = o_gnt; v_early = o_valid;
        i_req = 2'b00;
        @(posedge i_clk); #1;
        v = o_valid; id = o_id; r = o_result; s = o_status;
    endtask

    task automatic do_ack();
        i_ack = 1'b1;
        @(posedge i_clk); #1;
        i_ack = 1'b0;
        i_req = 2'b00;
    endtask

    task automatic test_reset();
        i_req = 2'b11;
        #2;
        checks++; if (o_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", o_gnt); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %b expected 0", o_id); end
        checks++; if (o_result !== 4'h0) begin errors++; $display("FAIL reset_result: got %b expected 0000", o_result); end
        checks++; if (o_status !== 4'h0) begin errors++; $display("FAIL reset_status: got %b expected 0000", o_status); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        i_req = 2'b00;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] a, b, r, s;
    } vec_t;

    task automatic test_directed();
        vec_t dv[7] = '{
            '{2'd0, 4'h3, 4'h5, 4'hA, 4'h6},
            '{2'd2, 4'hF, 4'h2, 4'hB, 4'h2},
            '{2'd2, 4'hF, 4'h4, 4'h0, 4'h1},
            '{2'd3, 4'hB, 4'h6, 4'hD, 4'h2},
            '{2'd3, 4'h8, 4'h3, 4'h0, 4'h1},
            '{2'd1, 4'hA, 4'h1, 4'h1, 4'h0},
            '{2'd0, 4'h7, 4'h9, 4'h0, 4'h1}
        };
        logic [1:0] g;
        logic ve, v, id;
        logic [3:0] r, s;
        foreach (dv[i]) begin
            txn(2'b01, dv[i].op, dv[i].a, dv[i].b, 2'($urandom), 4'($urandom), 4'($urandom), g, ve, v, id, r, s);
            checks++; if (g !== 2'b01) begin errors++; $display("FAIL dir%0d_gnt: got %b expected 01", i, g); end
            checks++; if (ve !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid: got %b expected 0", i, ve); end
            checks++; if (v !== 1'b1) begin errors++; $display("FAIL dir%0d_valid: got %b expected 1", i, v); end
            checks++; if (id !== 1'b0) begin errors++; $display("FAIL dir%0d_id: got %b expected 0", i, id); end
            checks++; if (r !== dv[i].r) begin errors++; $display("FAIL dir%0d_result: got %b expected %b", i, r, dv[i].r); end
            checks++; if (s !== dv[i].s) begin errors++; $display("FAIL dir%0d_status: got %b expected %b", i, s, dv[i].s); end
            do_ack();
            last_gnt = 1'b0;
            checks++;
            if ({o_valid, o_busy, o_result, o_status} !== {2'b00, dv[i].r, dv[i].s}) begin
                errors++; $display("FAIL dir%0d_after_ack: got v=%b busy=%b r=%b s=%b expected v=0 busy=0 r=%b s=%b",
                                   i, o_valid, o_busy, o_result, o_status, dv[i].r, dv[i].s);
            end
        end
    endtask

    task automatic test_round_robin();
        bit q[$];
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        last_gnt = 1'b1;
        i_req = 2'b11; i_ack = 1'b1;
        for (int c = 0; c < 20 && q.size() < 4; c++) begin
            @(posedge i_clk); #1;
            if (o_gnt != 2'b00) begin
                checks++; if (!$onehot(o_gnt)) begin errors++; $display("FAIL rr_onehot: got %b expected one-hot", o_gnt); end
                q.push_back(o_gnt[1]);
            end
        end
        i_req = 2'b00; i_ack = 1'b0;
        checks++; if (q.size() != 4) begin errors++; $display("FAIL rr_count: got %0d grants expected 4", q.size()); end
        foreach (q[i]) begin
            checks++; if (q[i] !== 1'(i % 2)) begin errors++; $display("FAIL rr_order%0d: got %0d expected %0d", i, q[i], i % 2); end
        end
        @(posedge i_clk); #1;
        do_ack();
        last_gnt = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0] req, op0, op1, g;
        logic [3:0] a0, b0, a1, b1, er, es, r, s;
        logic ve, v, id;
        bit w;
        for (int t = 0; t < 40; t++) begin
            req = 2'($urandom_range(1, 3));
            op0 = 2'($urandom); op1 = 2'($urandom);
            a0 = 4'($urandom); b0 = 4'($urandom_range(0, 15));
            a1 = 4'($urandom); b1 = 4'($urandom_range(0, 15));
            w = (req == 2'b11) ? !last_gnt : req[1];
            if (w) model(op1, a1, b1, er, es); else model(op0, a0, b0, er, es);
            txn(req, op0, a0, b0, op1, a1, b1, g, ve, v, id, r, s);
            checks++; if (g !== (w ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd%0d_gnt: got %b expected winner %0d", t, g, w); end
            checks++; if (id !== w || v !== 1'b1) begin errors++; $display("FAIL rnd%0d_id: got id=%b v=%b expected id=%b v=1", t, id, v, w); end
            checks++; if (r !== er) begin errors++; $display("FAIL rnd%0d_result: got %b expected %b", t, r, er); end
            checks++; if (s !== es) begin errors++; $display("FAIL rnd%0d_status: got %b expected %b", t, s, es); end
            repeat ($urandom_range(0, 3)) begin
                i_req = 2'($urandom);
                @(posedge i_clk); #1;
            end
            checks++;
            if ({o_valid, o_id, o_result, o_status} !== {1'b1, w, er, es}) begin
                errors++; $display("FAIL rnd%0d_hold: got v=%b id=%b r=%b s=%b expected v=1 id=%b r=%b s=%b",
                                   t, o_valid, o_id, o_result, o_status, w, er, es);
            end
            do_ack();
            last_gnt = w;
            checks++; if ({o_valid, o_busy, o_result} !== {2'b00, er}) begin errors++; $display("FAIL rnd%0d_ack: got v=%b busy=%b r=%b expected 0 0 %b", t, o_valid, o_busy, o_result, er); end
        end
    endtask

    task automatic test_reset_mid_resp();
        logic [1:0] g;
        logic ve, v, id;
        logic [3:0] r, s;
        txn(2'b01, 2'd0, 4'h5, 4'h1, 2'd0, 4'h0, 4'h0, g, ve, v, id, r, s);
        do_ack();
        txn(2'b10, 2'd0, 4'h0, 4'h0, 2'd0, 4'h6, 4'h2, g, ve, v, id, r, s);
        checks++; if (o_busy !== 1'b1 || o_valid !== 1'b1) begin errors++; $display("FAIL mid_resp_state: got busy=%b v=%b expected 1 1", o_busy, o_valid); end
        #2 i_rst = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", o_busy); end
        checks++; if ({o_gnt, o_id, o_result, o_status} !== 11'd0) begin errors++; $display("FAIL mid_rst_outputs: got gnt=%b id=%b r=%b s=%b expected zeros", o_gnt, o_id, o_result, o_status); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_resp: got %b expected 0", o_valid); end
        txn(2'b11, 2'd1, 4'h1, 4'h2, 2'd1, 4'h2, 4'h1, g, ve, v, id, r, s);
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL post_rst_gnt: got %b expected 01", g); end
        checks++; if (r !== 4'h1 || id !== 1'b0) begin errors++; $display("FAIL post_rst_result: got r=%b id=%b expected 0001 0", r, id); end
        do_ack();
    endtask

    initial begin
        i_rst = 1'b1; i_req = 2'b00; i_ack = 1'b0;
        i_op0 = '0; i_op1 = '0; i_argA0 = '0; i_argB0 = '0; i_argA1 = '0; i_argB1 = '0;
        repeat (2) @(posedge i_clk);
        #1;
        test_reset();
        i_rst = 1'b0;
        last_gnt = 1'b1;
        test_directed();
        test_round_robin();
        test_random();
        test_reset_mid_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
